// File: rtl/usr_pkg.sv
// Shared mode encoding for the universal shift register.
package usr_pkg;

   localparam int USR_MODE_W = 3;

   typedef enum logic [USR_MODE_W-1:0] {
      USR_HOLD = 3'b000,
      USR_SHL  = 3'b001,
      USR_SHR  = 3'b010,
      USR_LOAD = 3'b011,
      USR_ROL  = 3'b100,
      USR_ROR  = 3'b101
   } usr_mode_e;

endpackage : usr_pkg

// File: rtl/usr_word_counter.sv
// Counts shift steps and pulses word_valid when WIDTH steps complete a word.
module usr_word_counter #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic load,
   input  logic step,
   output logic word_valid
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;

   always_comb begin
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      if (clear || load) begin
         cnt_d = '0;
      end else if (step) begin
         // Reaching WIDTH is reported and wrapped in the same update.
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d   = '0;
            valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign word_valid = valid_q;

endmodule : usr_word_counter

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift / load / rotate with word-completion pulse.
// Define USR_ROTATE_EN to enable the ROL/ROR modes (otherwise they act as HOLD).
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [USR_MODE_W-1:0] mode,
   input  logic                  ser_in_r,
   input  logic                  ser_in_l,
   input  logic [WIDTH-1:0]      load_data,
   output logic [WIDTH-1:0]      data_out,
   output logic                  ser_out,
   output logic                  word_valid
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             ser_q, ser_d;
   logic             step;
   logic             load;
   usr_mode_e        mode_e;

   assign mode_e = usr_mode_e'(mode);

   always_comb begin
      data_d = data_q;
      ser_d  = ser_q;
      step   = 1'b0;
      load   = 1'b0;
      case (mode_e)
         USR_SHL: begin
            data_d = {data_q[WIDTH-2:0], ser_in_r};
            ser_d  = data_q[WIDTH-1];
            step   = 1'b1;
         end
         USR_SHR: begin
            data_d = {ser_in_l, data_q[WIDTH-1:1]};
            ser_d  = data_q[0];
            step   = 1'b1;
         end
         USR_LOAD: begin
            data_d = load_data;
            load   = 1'b1;
         end
`ifdef USR_ROTATE_EN
         USR_ROL: begin
            data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            ser_d  = data_q[WIDTH-1];
            step   = 1'b1;
         end
         USR_ROR: begin
            data_d = {data_q[0], data_q[WIDTH-1:1]};
            ser_d  = data_q[0];
            step   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= '0;
         ser_q  <= 1'b0;
      end else if (clear) begin
         data_q <= '0;
         ser_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         ser_q  <= ser_d;
      end
   end

   usr_word_counter #(
      .WIDTH(WIDTH)
   ) u_word_counter (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .load      (load),
      .step      (step),
      .word_valid(word_valid)
   );

   assign data_out = data_q;
   assign ser_out  = ser_q;

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8.
// Expectations for modes 100/101 follow the USR_ROTATE_EN setting of the build.
module tb_universal_shift_reg;

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHL  = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_LOAD = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ROR  = 3'b101;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       clear;
   logic [2:0] mode;
   logic       ser_in_r;
   logic       ser_in_l;
   logic [7:0] load_data;
   logic [7:0] data_out;
   logic       ser_out;
   logic       word_valid;

   int tests_run    = 0;
   int tests_failed = 0;

   universal_shift_reg #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .mode      (mode),
      .ser_in_r  (ser_in_r),
      .ser_in_l  (ser_in_l),
      .load_data (load_data),
      .data_out  (data_out),
      .ser_out   (ser_out),
      .word_valid(word_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one set of inputs, let one rising edge sample them, observe 1 ns later.
   task automatic cycle(input logic [2:0] m, input logic sr, input logic sl,
                        input logic [7:0] ld, input logic clr);
      mode      = m;
      ser_in_r  = sr;
      ser_in_l  = sl;
      load_data = ld;
      clear     = clr;
      @(posedge clk);
      #1;
      $display("[TB] t=%0t mode=%b clr=%b sr=%b sl=%b ld=%h -> data=%h ser=%b wv=%b",
               $time, m, clr, sr, sl, ld, data_out, ser_out, word_valid);
   endtask

   // n left shifts with constant serial bit; word_valid expected only on shift pulse_at (1-based).
   task automatic shl_run(input string tag, input int n, input logic sr, input int pulse_at);
      for (int i = 1; i <= n; i++) begin
         cycle(M_SHL, sr, 1'b0, 8'h00, 1'b0);
         check($sformatf("%s_wv%0d", tag, i), 64'(word_valid), 64'(i == pulse_at));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] pat;
      reset_n   = 1'b0;
      clear     = 1'b0;
      mode      = M_HOLD;
      ser_in_r  = 1'b0;
      ser_in_l  = 1'b0;
      load_data = 8'h00;
      #2;
      check("rst_data", 64'(data_out), 64'h00);
      check("rst_ser",  64'(ser_out),  64'h0);
      check("rst_wv",   64'(word_valid), 64'h0);
      #1 reset_n = 1'b1;

      // Eight left shifts of 1,0,1,1,0,0,1,0 build 8'hB2.
      pat = 8'b1011_0010;
      for (int i = 0; i < 8; i++) begin
         cycle(M_SHL, pat[7-i], 1'b0, 8'h00, 1'b0);
         check($sformatf("shl8_wv%0d", i + 1), 64'(word_valid), 64'(i == 7));
      end
      check("shl8_data", 64'(data_out), 64'hB2);
      check("shl8_ser",  64'(ser_out),  64'h0);

      cycle(M_LOAD, 1'b0, 1'b0, 8'hA5, 1'b0);
      check("load_a5_data", 64'(data_out), 64'hA5);
      check("load_a5_wv",   64'(word_valid), 64'h0);
      cycle(M_SHR, 1'b0, 1'b0, 8'h00, 1'b0);
      check("shr_data", 64'(data_out), 64'h52);
      check("shr_ser",  64'(ser_out),  64'h1);
      check("shr_wv",   64'(word_valid), 64'h0);

      cycle(M_LOAD, 1'b0, 1'b0, 8'h81, 1'b0);
      cycle(M_ROL, 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef USR_ROTATE_EN
      check("rol_data", 64'(data_out), 64'h03);
      check("rol_ser",  64'(ser_out),  64'h1);
      cycle(M_LOAD, 1'b0, 1'b0, 8'h81, 1'b0);
      cycle(M_ROR, 1'b0, 1'b0, 8'h00, 1'b0);
      check("ror_data", 64'(data_out), 64'hC0);
      check("ror_ser",  64'(ser_out),  64'h1);
`else
      check("rol_hold_data", 64'(data_out), 64'h81);
      check("rol_hold_ser",  64'(ser_out),  64'h1);
      cycle(M_ROR, 1'b0, 1'b0, 8'h00, 1'b0);
      check("ror_hold_data", 64'(data_out), 64'h81);
`endif
      check("rot_wv", 64'(word_valid), 64'h0);

      // LOAD landing where the 8th step would have been must not pulse.
      cycle(M_LOAD, 1'b0, 1'b0, 8'h00, 1'b0);
      shl_run("pre7", 7, 1'b1, 0);
      cycle(M_LOAD, 1'b0, 1'b0, 8'h3C, 1'b0);
      check("load_at8_wv",   64'(word_valid), 64'h0);
      check("load_at8_data", 64'(data_out), 64'h3C);
      check("load_at8_ser",  64'(ser_out),  64'h0);

      // Partial word discarded by LOAD, then two back-to-back words.
      shl_run("part5", 5, 1'b0, 0);
      cycle(M_LOAD, 1'b0, 1'b0, 8'h00, 1'b0);
      shl_run("word_a", 8, 1'b1, 8);
      check("word_a_data", 64'(data_out), 64'hFF);
      shl_run("word_b", 8, 1'b0, 8);
      check("word_b_data", 64'(data_out), 64'h00);
      check("word_b_ser",  64'(ser_out),  64'h1);

      // Clear beats a pending SHL.
      cycle(M_LOAD, 1'b0, 1'b0, 8'hFF, 1'b0);
      shl_run("pre_clr", 3, 1'b1, 0);
      check("pre_clr_ser", 64'(ser_out), 64'h1);
      cycle(M_SHL, 1'b1, 1'b0, 8'h00, 1'b1);
      check("clr_data", 64'(data_out), 64'h00);
      check("clr_ser",  64'(ser_out),  64'h0);
      check("clr_wv",   64'(word_valid), 64'h0);
      shl_run("post_clr", 8, 1'b1, 8);
      check("post_clr_data", 64'(data_out), 64'hFF);

      // Hold encodings leave everything alone.
      cycle(M_HOLD, 1'b0, 1'b1, 8'h55, 1'b0);
      check("hold0_data", 64'(data_out), 64'hFF);
      check("hold0_wv",   64'(word_valid), 64'h0);
      cycle(3'b111, 1'b0, 1'b1, 8'h55, 1'b0);
      check("hold7_data", 64'(data_out), 64'hFF);
      cycle(3'b110, 1'b0, 1'b1, 8'h55, 1'b0);
      check("hold6_data", 64'(data_out), 64'hFF);

      // Async reset pulse between edges after 3 shifts.
      cycle(M_LOAD, 1'b0, 1'b0, 8'h00, 1'b0);
      shl_run("pre_rst", 3, 1'b1, 0);
      check("pre_rst_data", 64'(data_out), 64'h07);
      #2 reset_n = 1'b0;
      #1;
      check("arst_data", 64'(data_out), 64'h00);
      check("arst_ser",  64'(ser_out),  64'h0);
      check("arst_wv",   64'(word_valid), 64'h0);
      #1 reset_n = 1'b1;
      shl_run("post_rst", 8, 1'b1, 8);
      check("post_rst_data", 64'(data_out), 64'hFF);
      cycle(M_HOLD, 1'b0, 1'b0, 8'h00, 1'b0);
      check("post_rst_wv_drop", 64'(word_valid), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_universal_shift_reg

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port clear, input, 1, synchronous clear of register, counter and ser_out.
REQ-005 The block SHALL have port mode, input, 3, operation select per REQ-011.
REQ-006 The block SHALL have port ser_in_r, input, 1, serial bit entering at LSB on left shift.
REQ-007 The block SHALL have port ser_in_l, input, 1, serial bit entering at MSB on right shift.
REQ-008 The block SHALL have port load_data, input, WIDTH, parallel load value.
REQ-009 The block SHALL have ports data_out (output, WIDTH, register contents), ser_out (output, 1, last bit shifted out) and word_valid (output, 1, one-cycle pulse on word completion).

Function
REQ-010 All outputs SHALL be registered and SHALL update on the rising clk edge after the controlling inputs are sampled (latency 1).
REQ-011 mode encoding SHALL be: 000 HOLD, 001 SHL, 010 SHR, 011 LOAD, 100 ROL, 101 ROR; 110 and 111 SHALL behave as HOLD.
REQ-012 SHL SHALL set data_out to {data_out[WIDTH-2:0], ser_in_r} and ser_out to the old data_out[WIDTH-1].
REQ-013 SHR SHALL set data_out to {ser_in_l, data_out[WIDTH-1:1]} and ser_out to the old data_out[0].
REQ-014 LOAD SHALL set data_out to load_data, set the shift counter to 0, and leave ser_out unchanged.
REQ-015 ROL and ROR SHALL rotate data_out by one bit without using serial inputs; ser_out SHALL take the bit that wraps.
REQ-016 HOLD SHALL leave data_out, ser_out and the counter unchanged; word_valid SHALL be 0.
REQ-017 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL increment by 1 on each SHL, SHR, ROL or ROR.
REQ-018 When an increment brings the counter to WIDTH, word_valid SHALL be 1 in the same cycle data_out shows the completed word, and the counter SHALL wrap to 0.
REQ-019 word_valid SHALL be 0 in every other cycle; back-to-back words SHALL produce pulses exactly WIDTH cycles apart.
REQ-020 clear SHALL have priority over mode: data_out, ser_out and the counter SHALL go to 0 and word_valid SHALL be 0.
REQ-021 LOAD in the cycle the counter would reach WIDTH SHALL suppress word_valid, because LOAD is not a shift.

Reset
REQ-022 While reset_n=0, data_out=0, ser_out=0, word_valid=0 and counter=0, independent of clk.
REQ-023 Deassertion of reset_n SHALL take effect at the next rising clk edge; a partially shifted word SHALL be discarded.

Configuration
REQ-024 Macro USR_ROTATE_EN SHALL control the rotate modes.
REQ-025 With USR_ROTATE_EN defined, ROL and ROR SHALL behave per REQ-015.
REQ-026 Without USR_ROTATE_EN, modes 100 and 101 SHALL behave as HOLD, no rotate logic SHALL be synthesised, and REQ-017 SHALL count only SHL and SHR.

Structure
REQ-027 Package usr_pkg SHALL hold the mode typedef/enum (USR_HOLD, USR_SHL, USR_SHR, USR_LOAD, USR_ROL, USR_ROR) and the 3-bit mode width constant.
REQ-028 Sub-module usr_word_counter SHALL hold the counter (parameter WIDTH; inputs clk, reset_n, clear, load, step; output word_valid).
REQ-029 The data path SHALL remain in universal_shift_reg.

Verification (WIDTH=8)
REQ-030 SHL for 8 cycles with ser_in_r = 1,0,1,1,0,0,1,0 -> data_out=8'hB2 and word_valid=1 only on the 8th update.
REQ-031 LOAD 8'hA5, then one SHR with ser_in_l=0 -> data_out=8'h52, ser_out=1, word_valid=0.
REQ-032 LOAD 8'h81, then ROL -> data_out=8'h03, ser_out=1 with USR_ROTATE_EN; data_out stays 8'h81 without it.
REQ-033 5 SHL, LOAD 8'h00, then 8 SHL -> word_valid only on the 8th shift after the load, not on the 3rd.
REQ-034 clear=1 with mode=SHL on data_out=8'hFF -> data_out=8'h00, ser_out=0, word_valid=0; the next 8 shifts pulse word_valid on the 8th.
REQ-035 reset_n pulsed low between clock edges after 3 shifts -> outputs 0 immediately; after release, 8 shifts are needed for word_valid.
